// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter for the memory-mapped peripheral bus: one latched access per grant, then an ack pulse.
// Optional macro ARB_M0_PRIO_EN selects fixed M0 priority instead of round-robin on a tie.
module periph_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_rd,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_rd,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          rd,
    output logic          wr,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata,
    output logic          owner,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic          last_r;
    logic          last_nx_s;
    logic          grant_s;
    logic          winner_s;
    logic          rd_nx_s;
    logic          wr_nx_s;
    logic [AW-1:0] addr_nx_s;
    logic [DW-1:0] wdata_nx_s;
    logic          m0_ack_nx_s;
    logic          m1_ack_nx_s;
    logic [DW-1:0] m0_rdata_nx_s;
    logic [DW-1:0] m1_rdata_nx_s;
    logic          owner_nx_s;
    logic          busy_nx_s;

    // Winner selection among pending requests
    always_comb begin
        grant_s  = m0_req | m1_req;
        winner_s = 1'b0;
        if (m0_req && m1_req) begin
`ifdef ARB_M0_PRIO_EN
            winner_s = 1'b0;
`else
            winner_s = ~last_r;
`endif
        end else if (m1_req) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Next-state and next-output computation; all outputs come straight from registers
    always_comb begin
        state_nx_s    = state_r;
        last_nx_s     = last_r;
        rd_nx_s       = 1'b0;
        wr_nx_s       = 1'b0;
        addr_nx_s     = addr;
        wdata_nx_s    = wdata;
        m0_ack_nx_s   = 1'b0;
        m1_ack_nx_s   = 1'b0;
        m0_rdata_nx_s = m0_rdata;
        m1_rdata_nx_s = m1_rdata;
        owner_nx_s    = owner;
        busy_nx_s     = busy;
        case (state_r)
            ST_ARB: begin
                if (grant_s) begin
                    state_nx_s = ST_ACCESS;
                    owner_nx_s = winner_s;
                    busy_nx_s  = 1'b1;
`ifndef ARB_M0_PRIO_EN
                    last_nx_s  = winner_s;
`endif
                    // A write command overrides a simultaneous read command
                    if (winner_s) begin
                        wr_nx_s    = m1_wr;
                        rd_nx_s    = m1_rd & ~m1_wr;
                        addr_nx_s  = m1_addr;
                        wdata_nx_s = m1_wdata;
                    end else begin
                        wr_nx_s    = m0_wr;
                        rd_nx_s    = m0_rd & ~m0_wr;
                        addr_nx_s  = m0_addr;
                        wdata_nx_s = m0_wdata;
                    end
                end else begin
                    busy_nx_s = 1'b0;
                end
            end
            ST_ACCESS: begin
                state_nx_s = ST_ACK;
                if (owner) begin
                    m1_ack_nx_s   = 1'b1;
                    m1_rdata_nx_s = rd ? rdata : {DW{1'b0}};
                end else begin
                    m0_ack_nx_s   = 1'b1;
                    m0_rdata_nx_s = rd ? rdata : {DW{1'b0}};
                end
            end
            ST_ACK: begin
                state_nx_s = ST_ARB;
                busy_nx_s  = 1'b0;
            end
            default: begin
                state_nx_s = ST_ARB;
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers; reset cuts any strobe off immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_ARB;
            last_r   <= 1'b1;
            rd       <= 1'b0;
            wr       <= 1'b0;
            addr     <= {AW{1'b0}};
            wdata    <= {DW{1'b0}};
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= {DW{1'b0}};
            m1_rdata <= {DW{1'b0}};
            owner    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            last_r   <= last_nx_s;
            rd       <= rd_nx_s;
            wr       <= wr_nx_s;
            addr     <= addr_nx_s;
            wdata    <= wdata_nx_s;
            m0_ack   <= m0_ack_nx_s;
            m1_ack   <= m1_ack_nx_s;
            m0_rdata <= m0_rdata_nx_s;
            m1_rdata <= m1_rdata_nx_s;
            owner    <= owner_nx_s;
            busy     <= busy_nx_s;
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: directed literal checks plus randomized traffic against a
// transaction-level timeline model (grant at edge g, strobe after g, ack after g+1, re-arbitrate at g+3).
module tb_periph_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          m0_req = 1'b0, m0_rd = 1'b0, m0_wr = 1'b0;
    logic [31:0]   m0_addr = 32'h0, m0_wdata = 32'h0;
    logic          m1_req = 1'b0, m1_rd = 1'b0, m1_wr = 1'b0;
    logic [31:0]   m1_addr = 32'h0, m1_wdata = 32'h0;
    logic          m0_ack, m1_ack, rd, wr, owner, busy;
    logic [31:0]   m0_rdata, m1_rdata, addr, wdata, rdata;

    periph_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    // Peripheral register file stand-in: read data is a pure function of the address
    function automatic logic [31:0] periph_f(input logic [31:0] a);
        if (a == 32'h4000_0010) return 32'h0000_00C3;
        else return a ^ 32'h3C3C_5A5A;
    endfunction
    assign rdata = periph_f(addr);

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    endtask

    // Timeline model: cyc counts edges, g is the edge at which the current transfer was granted
    int          cyc = 0;
    int          g = -100;
    int          ph;
    bit          last = 1'b1;
    bit          m_w;
    bit          cur_own, cur_rd, cur_wr;
    logic [31:0] cur_addr, cur_wdata;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            g    = -100;
            last = 1'b1;
        end else begin
            cyc++;
            if (cyc >= g + 3 && (m0_req || m1_req)) begin
                if (m0_req && m1_req) begin
`ifdef ARB_M0_PRIO_EN
                    m_w = 1'b0;
`else
                    m_w = ~last;
`endif
                end else begin
                    m_w = m1_req;
                end
                g         = cyc;
                cur_own   = m_w;
                cur_wr    = m_w ? m1_wr : m0_wr;
                cur_rd    = (m_w ? m1_rd : m0_rd) && !cur_wr;
                cur_addr  = m_w ? m1_addr : m0_addr;
                cur_wdata = m_w ? m1_wdata : m0_wdata;
`ifndef ARB_M0_PRIO_EN
                last      = m_w;
`endif
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            chk1("rst_rd", rd, 1'b0);
            chk1("rst_wr", wr, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_m0_ack", m0_ack, 1'b0);
            chk1("rst_m1_ack", m1_ack, 1'b0);
            chk1("rst_owner", owner, 1'b0);
            chk("rst_addr", addr, 32'h0);
            chk("rst_wdata", wdata, 32'h0);
            chk("rst_m0_rdata", m0_rdata, 32'h0);
            chk("rst_m1_rdata", m1_rdata, 32'h0);
        end else begin
            ph = cyc - g;
            chk1("rd", rd, ph == 0 && cur_rd);
            chk1("wr", wr, ph == 0 && cur_wr);
            chk1("busy", busy, ph == 0 || ph == 1);
            chk1("m0_ack", m0_ack, ph == 1 && !cur_own);
            chk1("m1_ack", m1_ack, ph == 1 && cur_own);
            if (ph == 0) begin
                chk("addr", addr, cur_addr);
                chk("wdata", wdata, cur_wdata);
            end
            if (ph == 0 || ph == 1) chk1("owner", owner, cur_own);
            if (ph == 1) begin
                if (cur_own) chk("m1_rdata", m1_rdata, cur_rd ? periph_f(cur_addr) : 32'h0);
                else chk("m0_rdata", m0_rdata, cur_rd ? periph_f(cur_addr) : 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic new_cmd(output logic r, output logic w, output logic [31:0] a, output logic [31:0] d);
        int c;
        c = $urandom_range(0, 3);
        r = (c == 1 || c == 3);
        w = (c >= 2);
        if ($urandom_range(0, 7) == 0) a = $urandom;
        else a = 32'h4000_0000 + 32'd4 * $urandom_range(0, 5);
        d = $urandom;
    endtask

    // Random master: holds a request until ack, sometimes drops early or scrambles its command
    task automatic step_m(input logic ack, inout logic req, inout logic r, inout logic w,
                          inout logic [31:0] a, inout logic [31:0] d);
        if (!req) begin
            if ($urandom_range(0, 2) == 0) begin
                req = 1'b1;
                new_cmd(r, w, a, d);
            end
        end else if (ack) begin
            if ($urandom_range(0, 1) == 0) new_cmd(r, w, a, d);
            else req = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
            req = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
            new_cmd(r, w, a, d);
        end
    endtask

    int got;
    int waited;
    int exp4 [4];

    initial begin
        // Reset with random inputs, then release with nothing requested
        for (int i = 0; i < 4; i++) begin
            m0_req = 1'($urandom); m0_rd = 1'($urandom); m0_wr = 1'($urandom); m0_addr = $urandom;
            m1_req = 1'($urandom); m1_rd = 1'($urandom); m1_wr = 1'($urandom); m1_addr = $urandom;
            tick();
            chk1("t1_busy", busy, 1'b0);
            chk1("t1_wr", wr, 1'b0);
            chk1("t1_acks", m0_ack | m1_ack, 1'b0);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("t1_idle_busy", busy, 1'b0);
        end

        // M0 write
        m0_req = 1'b1; m0_wr = 1'b1; m0_rd = 1'b0; m0_addr = 32'h4000_000C; m0_wdata = 32'h0000_005A;
        tick();
        chk1("t2_wr", wr, 1'b1);
        chk1("t2_rd", rd, 1'b0);
        chk("t2_addr", addr, 32'h4000_000C);
        chk("t2_wdata", wdata, 32'h0000_005A);
        tick();
        chk1("t2_m0_ack", m0_ack, 1'b1);
        chk1("t2_m1_ack", m1_ack, 1'b0);
        chk1("t2_wr_off", wr, 1'b0);
        m0_req = 1'b0;
        tick();
        chk1("t2_ack_off", m0_ack, 1'b0);

        // M1 read
        m1_req = 1'b1; m1_rd = 1'b1; m1_wr = 1'b0; m1_addr = 32'h4000_0010;
        tick();
        chk1("t3_rd", rd, 1'b1);
        chk("t3_addr", addr, 32'h4000_0010);
        tick();
        chk1("t3_m1_ack", m1_ack, 1'b1);
        chk1("t3_m0_ack", m0_ack, 1'b0);
        chk("t3_m1_rdata", m1_rdata, 32'h0000_00C3);
        m1_req = 1'b0;
        tick();

        // Both requesting continuously: grant order
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
`ifdef ARB_M0_PRIO_EN
        exp4 = '{0, 0, 0, 0};
`else
        exp4 = '{0, 1, 0, 1};
`endif
        m0_req = 1'b1; m0_rd = 1'b1; m0_wr = 1'b0; m0_addr = 32'h4000_0000;
        m1_req = 1'b1; m1_rd = 1'b1; m1_wr = 1'b0; m1_addr = 32'h4000_0004;
        for (int k = 0; k < 4; k++) begin
            got = -1;
            waited = 0;
            while (got < 0 && waited < 10) begin
                tick();
                waited++;
                if (m0_ack) got = 0;
                else if (m1_ack) got = 1;
            end
            chk("t4_grant", got, exp4[k]);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick(); tick();

        // Null transfer, then rd+wr together acting as a write
        m0_req = 1'b1; m0_rd = 1'b0; m0_wr = 1'b0; m0_addr = 32'h4000_0008;
        tick();
        chk1("t5_null_rd", rd, 1'b0);
        chk1("t5_null_wr", wr, 1'b0);
        chk1("t5_null_busy", busy, 1'b1);
        tick();
        chk1("t5_null_ack", m0_ack, 1'b1);
        chk("t5_null_rdata", m0_rdata, 32'h0);
        m0_rd = 1'b1; m0_wr = 1'b1;
        tick();
        tick();
        chk1("t5_both_wr", wr, 1'b1);
        chk1("t5_both_rd", rd, 1'b0);
        tick();
        chk1("t5_both_ack", m0_ack, 1'b1);
        chk("t5_both_rdata", m0_rdata, 32'h0);
        m0_req = 1'b0;
        tick();

        // Reset during the write strobe
        m0_req = 1'b1; m0_wr = 1'b1; m0_rd = 1'b0; m0_addr = 32'h4000_0014; m0_wdata = 32'h77;
        tick();
        chk1("t6_wr", wr, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk1("t6_wr_cut", wr, 1'b0);
        chk1("t6_busy_cut", busy, 1'b0);
        m0_req = 1'b0;
        tick();
        chk1("t6_no_ack", m0_ack, 1'b0);
        reset = 1'b1;
        tick();
        chk1("t6_no_ack2", m0_ack, 1'b0);
        m0_req = 1'b1; m0_rd = 1'b1; m0_wr = 1'b0; m0_addr = 32'h4000_0000;
        tick();
        chk1("t6_rd", rd, 1'b1);
        tick();
        chk1("t6_ack", m0_ack, 1'b1);
        chk("t6_rdata", m0_rdata, 32'h7C3C_5A5A);
        m0_req = 1'b0;
        tick();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                m0_req = 1'b0;
                m1_req = 1'b0;
                tick();
                tick();
                reset = 1'b1;
            end else begin
                step_m(m0_ack, m0_req, m0_rd, m0_wr, m0_addr, m0_wdata);
                step_m(m1_ack, m1_req, m1_rd, m1_wr, m1_addr, m1_wdata);
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
